// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-port ALU arbiter.
// Latency: n/a (types, constants and a pure grant-selection helper).
// Backpressure: n/a.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ALU control unit select encoding
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    // Value parked on the ALU select bus whenever no operation is executing
    localparam logic [3:0] SEL_IDLE = SEL_AND;

    // One-hot grant from two valids; prio picks the winner only on contention
    function automatic logic [1:0] pick_grant(input logic [1:0] valid, input logic prio);
        logic [1:0] g;
        g = valid;
        if (valid == 2'b11) begin
            g = prio ? 2'b10 : 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: two-port grant selection for the shared ALU (valid-qualified one-hot grant).
// Latency: grant is combinational from valid; priority pointer moves on the handshake edge.
// Backpressure: none; the caller qualifies the grant with its own idle condition.
// Build option: ALU_ARB_RR_EN enables the round-robin pointer; otherwise port 0 always wins.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       handshake,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    logic prio_q;
    logic prio_d;

    assign grant = pick_grant(valid, prio_q);

    // After a handshake the port that did not win gets priority next time
    always_comb begin
        prio_d = prio_q;
        if (handshake) begin
            prio_d = grant[0];
        end
    end

    // Priority pointer; port 0 favoured out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority has no state, so clock, reset and handshake are not needed here
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, handshake};

    assign grant = pick_grant(valid, 1'b0);
`endif

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external combinational ALU between two requesters, one op in flight.
// Latency: response valid two edges after the request handshake; new issue at most every 3 cycles.
// Backpressure: request ready is low while busy; the response is held until the owner's ready.
// Build option: ALU_ARB_RR_EN selects round-robin priority (default: fixed, port 0 wins).
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [3:0]       op_sel_q;
    logic             owner_q;
    logic             busy_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [1:0]       rsp_valid_q;

    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_d;
    logic [3:0]       op_sel_d;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_ready;
    logic [1:0]       grant;
    logic             handshake;
    logic             rsp_done;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    alu_arb_rr u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .handshake (handshake),
        .grant     (grant)
    );

    // Grant is already valid-qualified and one-hot; ready is held off during reset so no
    // handshake can be accepted before the first edge with reset released
    assign req_ready  = (state_q == IDLE && !rst) ? grant : 2'b00;
    assign handshake  = |req_ready;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    assign rsp_done = |(rsp_valid_q & rsp_ready);

    // Operands of whichever port wins this cycle
    always_comb begin
        op_a_d   = req0_a;
        op_b_d   = req0_b;
        op_sel_d = req0_sel;
        if (req_ready[1]) begin
            op_a_d   = req1_a;
            op_b_d   = req1_b;
            op_sel_d = req1_sel;
        end
    end

    // Operation FSM: capture on handshake, drive the ALU for one cycle, then hold the response.
    // Operand registers double as the ALU drive, so they are cleared when leaving EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= SEL_IDLE;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        op_a_q   <= op_a_d;
                        op_b_q   <= op_b_d;
                        op_sel_q <= op_sel_d;
                        owner_q  <= req_ready[1];
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                    op_a_q       <= '0;
                    op_b_q       <= '0;
                    op_sel_q     <= SEL_IDLE;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_sel    = op_sel_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model expects response two edges after each handshake.
// Backpressure: requester queues hold ops until accepted; response ready driven per scenario.
`timescale 1ns/1ps
module tb_alu_share_arb;

    localparam int W = 32;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sel;
    } op_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_sel = '0, req1_sel = '0;
    logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
    logic [3:0]   alu_sel;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic         busy;

    alu_share_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel);
        case (sel)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return '0;
        endcase
    endfunction

    // External shared ALU
    assign alu_result = alu_ref(alu_a, alu_b, alu_sel);

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel);
        op_t o;
        o.a = a; o.b = b; o.sel = sel;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = $urandom();
        o.b = $urandom();
        case ($urandom_range(0, 3))
            0:       o.sel = OP_AND;
            1:       o.sel = OP_OR;
            2:       o.sel = OP_ADD;
            default: o.sel = OP_SUB;
        endcase
        return o;
    endfunction

    // ---------------- reference model and monitor ----------------
    int           cyc = 0;
    bit           m_busy = 1'b0;
    bit           m_owner = 1'b0;
    bit           m_prio = 1'b0;
    int           m_t_hs = 0;
    logic [W-1:0] m_a, m_b, m_res;
    logic [3:0]   m_sel;
    logic [1:0]   sb_v, sb_rdy, sb_erdy, sb_erv;
    bit           hs0 = 1'b0, hs1 = 1'b0;
    int           last_hs_cyc = 0;
    int           grant_log[$];
    logic [W-1:0] rsp_res_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sb_v   = {req1_valid, req0_valid};
        sb_rdy = {req1_ready, req0_ready};
        hs0    = req0_valid && req0_ready;
        hs1    = req1_valid && req1_ready;
        if (rst) begin
            m_busy = 1'b0;
            m_prio = 1'b0;
            check("rst_ready", sb_rdy, 2'b00);
            check("rst_busy", busy, 1'b0);
            check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_sel", alu_sel, 0);
        end else begin
            sb_erdy = 2'b00;
            if (!m_busy) sb_erdy = (sb_v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : sb_v;
            check("ready", sb_rdy, sb_erdy);
            check("busy", busy, m_busy);
            sb_erv = 2'b00;
            if (m_busy && cyc >= m_t_hs + 2) sb_erv = m_owner ? 2'b10 : 2'b01;
            check("rsp_valid", {rsp1_valid, rsp0_valid}, sb_erv);
            if (sb_erv != 2'b00) check("rsp_result", rsp_result, m_res);
            if (!m_busy) begin
                check("idle_alu_a", alu_a, 0);
                check("idle_alu_b", alu_b, 0);
                check("idle_alu_sel", alu_sel, 0);
            end else if (cyc == m_t_hs + 1) begin
                check("exec_alu_a", alu_a, m_a);
                check("exec_alu_b", alu_b, m_b);
                check("exec_alu_sel", alu_sel, m_sel);
            end
            if (hs0) grant_log.push_back(0);
            if (hs1) grant_log.push_back(1);
            if (hs0 || hs1) last_hs_cyc = cyc;
            if (rsp0_valid && rsp0_ready) rsp_res_log.push_back(rsp_result);
            if (rsp1_valid && rsp1_ready) rsp_res_log.push_back(rsp_result);
            if (sb_erv != 2'b00) begin
                if (m_owner ? rsp1_ready : rsp0_ready) m_busy = 1'b0;
            end else if (!m_busy && sb_erdy != 2'b00) begin
                m_owner = sb_erdy[1];
                m_a     = m_owner ? req1_a : req0_a;
                m_b     = m_owner ? req1_b : req0_b;
                m_sel   = m_owner ? req1_sel : req0_sel;
                m_res   = alu_ref(m_a, m_b, m_sel);
                m_t_hs  = cyc;
                m_busy  = 1'b1;
`ifdef ALU_ARB_RR_EN
                m_prio  = ~m_owner;
`endif
            end
        end
    end

    // ---------------- requester drivers ----------------
    op_t q0[$], q1[$];
    bit  drv_en = 1'b1;
    bit  rand_mode = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
            if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
        end
        if (drv_en) begin
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                req0_a = q0[0].a; req0_b = q0[0].b; req0_sel = q0[0].sel;
                req0_valid = !(rand_mode && $urandom_range(0, 9) == 0);
            end else begin
                req0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                req1_a = q1[0].a; req1_b = q1[0].b; req1_sel = q1[0].sel;
                req1_valid = !(rand_mode && $urandom_range(0, 9) == 0);
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy && !rsp0_valid && !rsp1_valid) done = 1'b1;
        end
        check(tag, done, 1'b1);
        tick();
    endtask

    task automatic wait_rsp0(input string tag, output int t);
        bit found;
        found = 1'b0;
        t = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                found = 1'b1;
                t = cyc;
            end
        end
        check(tag, found, 1'b1);
    endtask

    function automatic int count_port1(input int from);
        int n;
        n = 0;
        for (int i = from; i < grant_log.size(); i++) if (grant_log[i] == 1) n++;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, nr;
        // Single op from port 0, presented while reset is still held
        q0.push_back(mk_op(5, 3, OP_ADD));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_rsp0("t031_rsp_seen", t);
        check("t031_latency", t - last_hs_cyc, 2);
        check("t031_result", rsp_result, 8);
        check("t031_rsp1_low", rsp1_valid, 1'b0);
        wait_idle("t031_idle");

        // Contention straight after reset; port 0 re-requests right away
        do_reset();
        n = grant_log.size();
        nr = rsp_res_log.size();
        q0.push_back(mk_op(5, 3, OP_ADD));
        q0.push_back(mk_op(1, 1, OP_OR));
        q1.push_back(mk_op(9, 4, OP_SUB));
        wait_idle("t032_idle");
        check("t032_grants", grant_log.size() - n, 3);
        if (grant_log.size() >= n + 3 && rsp_res_log.size() >= nr + 3) begin
            check("t032_g0", grant_log[n], 0);
            check("t032_g1", grant_log[n+1], RR ? 1 : 0);
            check("t032_g2", grant_log[n+2], RR ? 0 : 1);
            check("t032_r0", rsp_res_log[nr], 8);
            check("t032_r1", rsp_res_log[nr+1], RR ? 5 : 1);
            check("t032_r2", rsp_res_log[nr+2], RR ? 1 : 5);
        end

        // Both ports continuously valid for several ops
        do_reset();
        n = grant_log.size();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk_op(k, 1, OP_ADD));
            q1.push_back(mk_op(10 * k, 2, OP_SUB));
        end
        wait_idle("t033_idle");
        check("t033_grants", grant_log.size() - n, 8);
        if (grant_log.size() >= n + 4)
            for (int k = 0; k < 4; k++) check("t033_grant", grant_log[n+k], RR ? (k % 2) : 0);

        // Response stall with port 1 waiting
        do_reset();
        rsp0_ready = 1'b0;
        nr = rsp_res_log.size();
        q0.push_back(mk_op(7, 2, OP_SUB));
        q1.push_back(mk_op(1, 2, OP_ADD));
        wait_rsp0("t034_rsp_seen", t);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("t034_rsp0_valid", rsp0_valid, 1'b1);
            check("t034_result", rsp_result, 5);
            check("t034_req1_ready", req1_ready, 1'b0);
            check("t034_busy", busy, 1'b1);
        end
        tick();
        rsp0_ready = 1'b1;
        wait_idle("t034_idle");
        check("t034_rsp_count", rsp_res_log.size() - nr, 2);
        if (rsp_res_log.size() >= nr + 2) check("t034_r1", rsp_res_log[nr+1], 3);

        // Reset in the middle of EXEC
        drv_en = 1'b0;
        nr = rsp_res_log.size();
        req0_a = 3; req0_b = 4; req0_sel = OP_ADD; req0_valid = 1'b1;
        @(negedge clk);
        check("t035_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        check("t035_exec_sel", alu_sel, OP_ADD);
        #1 rst = 1'b1;
        #1;
        check("t035_busy", busy, 1'b0);
        check("t035_alu_sel", alu_sel, 0);
        check("t035_alu_a", alu_a, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("t035_no_rsp", rsp_res_log.size() - nr, 0);

        // Port 1 pulses valid during EXEC only
        n = grant_log.size();
        req0_a = 6; req0_b = 6; req0_sel = OP_AND; req0_valid = 1'b1;
        @(negedge clk);
        check("t036_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_a = 2; req1_b = 2; req1_sel = OP_OR; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        repeat (6) tick();
        check("t036_port1_grants", count_port1(n), 0);
        check("t036_grants", grant_log.size() - n, 1);
        drv_en = 1'b1;

        // Randomized traffic with one reset in the middle
        n = grant_log.size();
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
            end
        end
        rand_mode = 1'b0;
        tick();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        wait_idle("rand_idle");
        check("rand_activity", (grant_log.size() - n) > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
